serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 20 ++
 rtl/serial_adder_ctrl_if.sv | 44 ++++
 rtl/serial_adder_ctrl_fa.sv | 50 +++++
 rtl/serial_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Purpose : shared definitions for the serial adder controller slice.
//           Holds the FSM state encoding and the default operand width.
// Ports   : none (package).
// Config  : SERIAL_ADD_OVF_EN (used by the interface and top, not here).
// ---------------------------------------------------------------------------
package serial_add_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states, encoded explicitly so the values stay fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
// Purpose : bundles the request/response signals of the serial adder.
// Signals : start, a, b, cin   - request side (driven by the master)
//           busy, done, sum, cout - response side (driven by the adder)
//           ovf                 - signed overflow, only when
//                                 SERIAL_ADD_OVF_EN is defined
// Modports: master (requester), slave (the adder controller).
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );

endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl_fa.sv
// ---------------------------------------------------------------------------
// half_adder_structural / full_adder_cell
// Purpose : the single-bit arithmetic of the serial adder, built from gates.
//           full_adder_cell = two half adders plus an OR for the carry.
// Ports   : half_adder_structural: i_a, i_b -> o_s, o_c
//           full_adder_cell      : i_a, i_b, i_cin -> o_s, o_cout
// Config  : none.
// ---------------------------------------------------------------------------
module half_adder_structural (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  xor u_xor (o_s, i_a, i_b);
  and u_and (o_c, i_a, i_b);

endmodule : half_adder_structural

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder_structural u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  half_adder_structural u_ha1 (
    .i_a (w_s0),
    .i_b (i_cin),
    .o_s (o_s),
    .o_c (w_c1)
  );

  // Both half adders can never carry at once, so OR merges the carries.
  or u_or (o_cout, w_c0, w_c1);

endmodule : full_adder_cell

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Purpose : bit-serial adder. On an accepted start the operands are captured,
//           then one bit per clock is added LSB first through a single
//           full_adder_cell. The result is assembled in a shadow register and
//           published to sum/cout (and ovf) only when the run finishes, so the
//           visible result never changes mid-run.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - serial_adder_ctrl_if.slave (start, a, b, cin in;
//                    busy, done, sum, cout [, ovf] out)
// Config  : SERIAL_ADD_OVF_EN - when defined, adds the registered signed
//           overflow output ovf = (carry into MSB) ^ cout.
// ---------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  // Counter gets one spare bit so it can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic [IW-1:0]    w_idx;
  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  // The low counter bits address the operand bit being processed this cycle.
  assign w_idx   = r_cnt[IW-1:0];
  assign w_bit_a = r_a[w_idx];
  assign w_bit_b = r_b[w_idx];
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  full_adder_cell u_fa (
    .i_a    (w_bit_a),
    .i_b    (w_bit_b),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  // Single FSM block. Sum bits enter the shadow register from the top so that
  // after WIDTH shifts bit 0 sits at position 0. On the final step the
  // completed word, the final carry and (optionally) the overflow are
  // committed together; r_carry at that point is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_carry  <= bus.cin;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_shadow <= {w_s, r_shadow[WIDTH-1:1]};
          r_carry  <= w_c;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= {w_s, r_shadow[WIDTH-1:1]};
            r_cout  <= w_c;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= r_carry ^ w_c;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Purpose : self-checking bench for serial_adder_ctrl at WIDTH=8. Expected
//           results come from plain integer addition of the operands.
// Config  : honours SERIAL_ADD_OVF_EN (checks ovf only when defined).
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  // Last published result as predicted by the reference model.
  logic [W-1:0] prevSum;
  logic         prevCout;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence gets stuck somewhere.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete add: drives operands, follows the run cycle by cycle and
  // checks busy/done timing, the held result during RUN and the final result.
  task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input logic opCin, input bit holdStart,
                               input bit pulseMid);
    int           total;
    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;
    total   = int'(opA) + int'(opB) + int'(opCin);
    expSum  = total[W-1:0];
    expCout = total[W];
    expOvf  = (opA[W-1] == opB[W-1]) && (expSum[W-1] != opA[W-1]);

    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = opA;
    bus.b     = opB;
    bus.cin   = opCin;
    @(posedge clk);
    #1;
    checkOutput("accept_busy", 32'(bus.busy), 32'd1);

    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      // Operands wander during the run; a captured run must not see them.
      bus.a   = (pulseMid && i == 3) ? 8'hAA : W'($urandom);
      bus.b   = W'($urandom);
      bus.cin = 1'($urandom);
      bus.start = holdStart ? 1'b1 : (pulseMid && i == 3);
      @(posedge clk);
      #1;
      if (i < W) begin
        checkOutput("run_busy", 32'(bus.busy), 32'd1);
        checkOutput("run_done", 32'(bus.done), 32'd0);
        checkOutput("run_sum_held", 32'(bus.sum), 32'(prevSum));
        checkOutput("run_cout_held", 32'(bus.cout), 32'(prevCout));
      end else begin
        checkOutput("done_pulse", 32'(bus.done), 32'd1);
        checkOutput("done_busy", 32'(bus.busy), 32'd0);
        checkOutput("sum", 32'(bus.sum), 32'(expSum));
        checkOutput("cout", 32'(bus.cout), 32'(expCout));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("ovf", 32'(bus.ovf), 32'(expOvf));
`else
        if (expOvf) begin
          // ovf is not present in this build; nothing to compare.
        end
`endif
      end
    end

    @(negedge clk);
    bus.start = holdStart;
    @(posedge clk);
    #1;
    checkOutput("done_single_cycle", 32'(bus.done), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("sum_hold", 32'(bus.sum), 32'(expSum));
    prevSum  = expSum;
    prevCout = expCout;
  endtask

  initial begin
    int doneSeen;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    prevSum   = '0;
    prevCout  = 1'b0;

    // Reset state.
    #2;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_sum", 32'(bus.sum), 32'd0);
    checkOutput("reset_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 1..4: directed operands.
    $display("[TB] directed operands");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_start_ignored", 32'(bus.busy), 32'd0);

    // Test 5: reset four edges into a run.
    $display("[TB] reset during run");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h66;
    bus.cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_sum", 32'(bus.sum), 32'd0);
    checkOutput("abort_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
    prevSum  = '0;
    prevCout = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen++;
    end
    checkOutput("no_done_after_abort", 32'(doneSeen), 32'd0);
    applyStimulus(8'h55, 8'h66, 1'b0, 1'b0, 1'b0);

    // Randomized operands.
    $display("[TB] random operands");
    for (int n = 0; n < 8; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    // Test 6: start held high, one op every WIDTH+2 cycles.
    $display("[TB] start held high");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
